// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with per-grant hold limit and forced-release timeout flag.
// Latency: grant registered one edge after a request is sampled; one idle turnaround cycle between grants.
// Backpressure: none; an owner keeps the grant until done, request drop or MAX_HOLD cycles.
module rr_arb4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [1:0]        last_id, last_id_nxt;
    logic [1:0]        gnt_id_nxt;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [3:0]        gnt_nxt;
    logic              gnt_vld_nxt, timeout_nxt;
    logic              any_req, own_req, hold_max, grant_end;

    assign any_req   = |req;
    assign own_req   = req[gnt_id];
    assign hold_max  = (cnt == HOLD_LAST);
    assign grant_end = done | ~own_req | hold_max;

    // Scan from lowest to highest priority so the agent right after last_id wins.
    always_comb begin
        winner = last_id;
        idx    = last_id;
        for (int k = 4; k >= 1; k--) begin
            idx = last_id + 2'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_id <= 2'b11;
            cnt     <= '0;
            gnt_id  <= 2'b00;
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_id <= last_id_nxt;
            cnt     <= cnt_nxt;
            gnt_id  <= gnt_id_nxt;
            gnt     <= gnt_nxt;
            gnt_vld <= gnt_vld_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (grant_end) state_nxt = REL;
            REL:     state_nxt = any_req ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output, so no input reaches a port combinationally.
    always_comb begin
        gnt_id_nxt  = gnt_id;
        last_id_nxt = last_id;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            GRANT: begin
                if (grant_end) begin
                    last_id_nxt = gnt_id;
                    cnt_nxt     = '0;
                    timeout_nxt = ~done & own_req & hold_max;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                if (any_req) begin
                    gnt_id_nxt = winner;
                    cnt_nxt    = '0;
                end
            end
        endcase
        gnt_vld_nxt = (state_nxt == GRANT);
        gnt_nxt     = gnt_vld_nxt ? (4'b0001 << gnt_id_nxt) : 4'b0000;
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Randomized and directed bench for rr_arb4: a reference model queues expected outputs per edge,
// a monitor pops and compares after every rising edge and after every asynchronous reset assertion.
module tb_rr_arb4;

    localparam int MAX_HOLD = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] gid;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the resource, how many cycles it has held it, who owned it last.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_last  = 3;
    int   m_gid   = 0;
    bit   m_to    = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_gid   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    // One rising edge with inputs r/d sampled; a free resource is arbitrated, an owned one may be released.
    function automatic void model_step(input logic [3:0] r, input logic d);
        int p;
        if (m_owner >= 0) begin
            if (d || !r[m_owner] || m_held == MAX_HOLD) begin
                m_to    = !d && r[m_owner] && (m_held == MAX_HOLD);
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_held = m_held + 1;
                m_to   = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            p    = pick(r);
            if (p >= 0) begin
                m_owner = p;
                m_gid   = p;
                m_held  = 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.gid = 2'(m_gid);
        e.vld = (m_owner >= 0);
        e.to  = m_to;
        return e;
    endfunction

    task automatic check_one(input string tag);
        exp_t got, e;
        got = {gnt, gnt_id, gnt_vld, timeout};
        n_checks++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL %s @%0t: output without expectation, got gnt=%b id=%0d vld=%b to=%b",
                     tag, $time, got.gnt, got.gid, got.vld, got.to);
        end else begin
            e = expq.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got gnt=%b id=%0d vld=%b to=%b, required gnt=%b id=%0d vld=%b to=%b",
                         tag, $time, got.gnt, got.gid, got.vld, got.to, e.gnt, e.gid, e.vld, e.to);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_one("edge");
    end

    always @(negedge rst_n) begin
        #1;
        check_one("async_reset");
    end

    // Drive one cycle: inputs set away from the edge, expectation for the coming edge queued.
    task automatic cyc(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        if (!rst_n) model_reset();
        else        model_step(r, d);
        expq.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic hit_reset();
        #2;
        model_reset();
        expq.push_back(model_out());
        rst_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic       d;
        #1;
        req = 4'b1111;
        hit_reset();
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b0);
        rst_n = 1'b1;
        // First grant after reset goes to agent 0, then full rotation with done every grant cycle.
        cyc(4'b1111, 1'b0);
        repeat (10) cyc(4'b1111, 1'b1);
        repeat (3) cyc(4'b0000, 1'b0);

        // Single requester, done on the third grant cycle, then re-grant.
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0100, (m_owner >= 0 && m_held == 3));
        end
        repeat (3) cyc(4'b0000, 1'b0);

        // Lone holder never releases: forced release at MAX_HOLD, timeout pulse, re-grant.
        repeat (2 * (MAX_HOLD + 1) + 3) cyc(4'b0010, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0);

        // done exactly on the last allowed cycle is a normal release.
        for (int i = 0; i < 2 * (MAX_HOLD + 1) + 2; i++) begin
            cyc(4'b0001, (m_owner >= 0 && m_held == MAX_HOLD));
        end
        repeat (3) cyc(4'b0000, 1'b0);

        // Owner drops its request in the second grant cycle.
        for (int i = 0; i < 10; i++) begin
            cyc((m_owner >= 0 && m_held == 2) ? 4'b0000 : 4'b1000, 1'b0);
        end
        repeat (3) cyc(4'b0000, 1'b0);

        // Pointer at agent 1 with agents 0 and 3 requesting: 3 wins; reset mid-grant, then 0 wins.
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b1);
        cyc(4'b1001, 1'b0);
        cyc(4'b1001, 1'b0);
        hit_reset();
        cyc(4'b1001, 1'b0);
        rst_n = 1'b1;
        repeat (3) cyc(4'b1001, 1'b0);

        // Random traffic: sticky requests, occasional done, rare asynchronous resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            d = ($urandom_range(3) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(499) == 0) hit_reset();
            cyc(r, d);
        end
        rst_n = 1'b1;
        repeat (2) cyc(4'b0000, 1'b0);

        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
